// File: rtl/key_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_seq_pkg: shared types and defaults for the key-sequence sender |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package key_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam int         c_DEF_PRE_LEN  = 4;
  localparam logic [3:0] c_DEF_PREAMBLE = 4'b1010;

  // Width of a counter that must reach n without wrapping.
  function automatic int cnt_width(input int n);
    return (n + 1 <= 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int c_DEF_CNT_W = cnt_width(c_DEF_PRE_LEN);

endpackage
`default_nettype wire

// File: rtl/key_bit_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_bit_shifter: parallel-load, MSB-out shift register, zero fill  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module key_bit_shifter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sh;

  // Zero fill means the MSB reads 0 once every loaded bit has shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else if (i_clear) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/key_seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_seq_tx: serial unlock/mode command generator for key decoder   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module key_seq_tx
  import key_seq_pkg::*;
#(
  parameter int               PRE_LEN  = c_DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0] PREAMBLE = c_DEF_PREAMBLE
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode_in,
  input  logic abort,
  output logic input_key,
  output logic valid_cmd,
  output logic busy,
  output logic done,
  output logic locked,
  output logic mode_sent,
  output logic reject
);

  localparam int               c_CNT_W = cnt_width(PRE_LEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PRE_LEN);

  state_t             r_state, w_state_nx;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nx;
  logic               r_valid, w_valid_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;
  logic               r_locked, w_locked_nx;
  logic               r_reject, w_reject_nx;
  logic               r_mode, w_mode_nx;
  logic               r_mode_sent, w_mode_sent_nx;
  logic               w_load, w_shift, w_clear;
  logic               w_key;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_locked    <= 1'b0;
      r_reject    <= 1'b0;
      r_mode      <= 1'b0;
      r_mode_sent <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_valid     <= w_valid_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_locked    <= w_locked_nx;
      r_reject    <= w_reject_nx;
      r_mode      <= w_mode_nx;
      r_mode_sent <= w_mode_sent_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_valid_nx     = 1'b0;
    w_busy_nx      = 1'b0;
    w_done_nx      = 1'b0;
    w_locked_nx    = r_locked;
    w_reject_nx    = 1'b0;
    w_mode_nx      = r_mode;
    w_mode_sent_nx = r_mode_sent;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = SEND;
          w_cnt_nx   = '0;
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_mode_nx  = mode_in;
          w_load     = 1'b1;
        end
      end
      SEND: begin
        // Abort on the final bit is too late: the decoder has it already.
        if (abort && (r_cnt != c_LAST)) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_clear    = 1'b1;
        end else if (r_cnt == c_LAST) begin
          w_state_nx     = LOCKED;
          w_locked_nx    = 1'b1;
          w_done_nx      = 1'b1;
          w_mode_sent_nx = r_mode;
          w_shift        = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + c_CNT_W'(1);
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_shift    = 1'b1;
        end
      end
      LOCKED: begin
        w_reject_nx = start;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  key_bit_shifter #(
    .WIDTH (PRE_LEN + 1)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ({PREAMBLE, mode_in}),
    .o_msb   (w_key)
  );

  assign input_key = w_key;
  assign valid_cmd = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign locked    = r_locked;
  assign mode_sent = r_mode_sent;
  assign reject    = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_key_seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_seq_tx: directed self-checking bench with a decoder model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_key_seq_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mode_in = 1'b0;
  logic abort = 1'b0;
  logic input_key, valid_cmd, busy, done, locked, mode_sent, reject;

  int n_checks = 0;
  int n_errors = 0;

  key_seq_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode_in   (mode_in),
    .abort     (abort),
    .input_key (input_key),
    .valid_cmd (valid_cmd),
    .busy      (busy),
    .done      (done),
    .locked    (locked),
    .mode_sent (mode_sent),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  // Receiving decoder: needs 1010 then a mode bit with no gaps in valid_cmd.
  logic [3:0] d_sh;
  int         d_cnt;
  logic       d_active, d_mode;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_sh <= 4'b0; d_cnt <= 0; d_active <= 1'b0; d_mode <= 1'b0;
    end else if (!d_active) begin
      if (valid_cmd) begin
        if (d_cnt == 4) begin
          d_cnt <= 0;
          if (d_sh == 4'b1010) begin
            d_active <= 1'b1;
            d_mode   <= input_key;
          end
        end else begin
          d_sh  <= {d_sh[2:0], input_key};
          d_cnt <= d_cnt + 1;
        end
      end else begin
        d_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key"},    input_key, 1'b0);
    chk({tag, "_valid"},  valid_cmd, 1'b0);
    chk({tag, "_busy"},   busy,      1'b0);
    chk({tag, "_done"},   done,      1'b0);
    chk({tag, "_locked"}, locked,    1'b0);
    chk({tag, "_mode"},   mode_sent, 1'b0);
    chk({tag, "_reject"}, reject,    1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk_zero("reset");
    chk("reset_dec_active", d_active, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  task automatic send_and_check(input logic m, input logic abort_last);
    logic [4:0] exp_bits;
    exp_bits = {4'b1010, m};
    start = 1'b1; mode_in = m;
    tick();
    start = 1'b0; mode_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("send_valid", valid_cmd, 1'b1);
      chk("send_busy",  busy,      1'b1);
      chk("send_key",   input_key, exp_bits[4-k]);
      chk("send_done",  done,      1'b0);
      if (k == 4 && abort_last) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk("end_done",   done,      1'b1);
    chk("end_locked", locked,    1'b1);
    chk("end_valid",  valid_cmd, 1'b0);
    chk("end_busy",   busy,      1'b0);
    chk("end_key",    input_key, 1'b0);
    chk("end_mode",   mode_sent, m);
    tick();
    chk("post_done",   done,      1'b0);
    chk("post_locked", locked,    1'b1);
    chk("dec_active",  d_active,  1'b1);
    chk("dec_mode",    d_mode,    m);
  endtask

  initial begin
    #3;
    chk_zero("por");
    tick();
    reset = 1'b1;

    // 1: full command, mode 1
    send_and_check(1'b1, 1'b0);

    // 5: start while locked is refused
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_pulse",  reject,    1'b1);
    chk("rej_valid",  valid_cmd, 1'b0);
    chk("rej_locked", locked,    1'b1);
    tick();
    chk("rej_once",   reject,    1'b0);
    chk("rej_valid2", valid_cmd, 1'b0);
    chk("rej_locked2", locked,   1'b1);

    // 2: full command, mode 0
    do_reset();
    send_and_check(1'b0, 1'b0);

    // 3: abort during the third bit, then a clean resend
    do_reset();
    start = 1'b1; mode_in = 1'b1;
    tick();
    start = 1'b0; mode_in = 1'b0;
    chk("ab_b0", input_key, 1'b1);
    tick();
    chk("ab_b1", input_key, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_b2", input_key, 1'b1);
    chk("ab_ign_start", reject, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", valid_cmd, 1'b0);
    chk("ab_busy",  busy,      1'b0);
    chk("ab_key",   input_key, 1'b0);
    chk("ab_done",  done,      1'b0);
    tick();
    chk("ab_done2",   done,     1'b0);
    chk("ab_locked",  locked,   1'b0);
    chk("ab_dec_idle", d_active, 1'b0);
    send_and_check(1'b1, 1'b0);

    // 4: abort on the final bit is ignored
    do_reset();
    send_and_check(1'b1, 1'b1);

    // 6: asynchronous reset in the middle of the second bit
    do_reset();
    start = 1'b1; mode_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("mid_b1_valid", valid_cmd, 1'b1);
    reset = 1'b0;
    #1;
    chk_zero("async");
    chk("async_dec", d_active, 1'b0);
    #2;
    reset = 1'b1;
    tick();
    chk_zero("after_rel");
    send_and_check(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
